lm35_temp_reader: RTL and testbench
===================================

Name: lm35_temp_reader

Overview:
- Reads board temperature from the LM35DM sensor through an 8-bit serial ADC. The ADC uses a 2.56 V reference, so 1 LSB = 10 mV = 1 degC.
- The block periodically runs a 3-wire conversion frame (CS_N, SCLK, DOUT) and averages 2^AVG_LOG2 samples.
- It publishes the averaged temperature plus an over-temperature flag with hysteresis to TUB status/alarm logic.

Parameters:
- CLK_DIV, 4: CLK cycles per ADC_SCLK half-period (>=1).
- SAMPLE_INTERVAL, 4096: CLK cycles between conversion starts (>=1).
- AVG_LOG2, 2: log2 of samples per average (0..4).
- TEMP_HI, 8'd45: OVERTEMP set threshold, in degC codes.
- TEMP_LO, 8'd40: OVERTEMP clear threshold, in degC codes (TEMP_LO < TEMP_HI).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ENABLE  input  1  level; permits new conversions.
- ADC_DOUT  input  1  serial data from ADC, MSB first.
- ADC_CS_N  output  1  ADC chip select, active low.
- ADC_SCLK  output  1  ADC serial clock, idles low.
- SAMPLE  output  8  last raw ADC code.
- TEMP  output  8  averaged temperature code.
- TEMP_VALID  output  1  one-CLK pulse when TEMP updates.
- OVERTEMP  output  1  hysteretic alarm flag.
- BUSY  output  1  high while a frame is in progress (CS_N low or DESELECT).

Behaviour:

Reset values (asynchronous, immediate, including mid-frame):
- ADC_CS_N=1, ADC_SCLK=0, SAMPLE=0, TEMP=0, TEMP_VALID=0, OVERTEMP=0, BUSY=0.
- Accumulator, sample count and interval counter cleared; state=IDLE.

Interval counter:
- While ENABLE=1, decrements each CLK.
- Reloads SAMPLE_INTERVAL-1 on each frame start.
- While ENABLE=0, held at 0, so the first frame starts on the first IDLE cycle with ENABLE=1.

FSM states:
- IDLE: start a frame when ENABLE=1 and interval counter=0. If the counter already reached 0 during a frame, the next frame starts on the first IDLE cycle (back-to-back, no error).
- SELECT: ADC_CS_N=0, ADC_SCLK=0 for CLK_DIV cycles of setup.
- SHIFT: 9 SCLK periods. Each period is CLK_DIV cycles high then CLK_DIV cycles low.
  - ADC_DOUT is captured on the CLK edge that drives ADC_SCLK 1->0.
  - Bit 0 is the ADC null bit and is discarded.
  - Bits 1..8 are shifted in MSB first.
- DESELECT: ADC_CS_N=1, ADC_SCLK=0 for CLK_DIV cycles. On the first DESELECT edge, SAMPLE takes the shifted code.
- ACCUM: 1 cycle, then IDLE.
  - The accumulator (8+AVG_LOG2 bits, no overflow possible) adds SAMPLE and the count increments.
  - When the count reaches 2^AVG_LOG2: TEMP <= accum>>AVG_LOG2 (truncate), TEMP_VALID=1 on the following cycle only, accumulator and count cleared.

Frame length:
- CS_N is low for CLK_DIV + 18*CLK_DIV CLK cycles.
- Total frame: 20*CLK_DIV + 1 cycles.

OVERTEMP (updated on the same edge as TEMP):
- Set if new TEMP >= TEMP_HI.
- Cleared if new TEMP <= TEMP_LO.
- Otherwise held.
- Never changes between TEMP updates.

ENABLE deasserted mid-frame:
- The frame completes normally; SAMPLE updates.
- The partial average (accumulator and count) is discarded; no TEMP_VALID.
- TEMP and OVERTEMP hold. Return to IDLE.

Boundary behaviour:
- AVG_LOG2=0: every frame produces TEMP=SAMPLE plus TEMP_VALID.
- Codes 0x00 and 0xFF pass unmodified.

Test Plan:
- Reset/idle: RESET pulse with ENABLE=0 for 100 cycles -> CS_N=1, SCLK=0, all outputs 0, no SCLK toggles.
- Single frame: CLK_DIV=2, AVG_LOG2=0, ADC model drives code 0x2A -> CS_N low exactly 38 cycles, 9 SCLK pulses each 2 high/2 low. SAMPLE=TEMP=0x2A, TEMP_VALID one cycle. Frame start to TEMP_VALID is 42 cycles.
- Averaging truncation: AVG_LOG2=2, codes 20,21,21,21 -> single TEMP_VALID after the 4th frame, TEMP=20. No pulse after frames 1-3.
- Hysteresis: AVG_LOG2=0, codes 44,45,42,40,41 -> OVERTEMP 0,1,1,0,0, each change coincident with TEMP_VALID.
- Interval/back-to-back: SAMPLE_INTERVAL=200 -> frame starts exactly 200 cycles apart. SAMPLE_INTERVAL=10 -> frames separated only by the ACCUM/IDLE cycle, no dropped or overlapping frames.
- Disturbances:
  - ENABLE dropped during the 2nd of 4 averaging frames -> frame finishes, no TEMP_VALID, next enabled run averages 4 fresh samples.
  - RESET asserted mid-SHIFT -> CS_N=1 and SCLK=0 immediately, outputs 0.

Source files
------------

// File: rtl/lm35_temp_reader.sv
// LM35DM temperature reader: frames an 8-bit serial ADC conversion, averages
// 2^AVG_LOG2 samples and raises a hysteretic over-temperature flag.
module lm35_temp_reader #(
  parameter int unsigned CLK_DIV         = 4,
  parameter int unsigned SAMPLE_INTERVAL = 4096,
  parameter int unsigned AVG_LOG2        = 2,
  parameter logic [7:0]  TEMP_HI         = 8'd45,
  parameter logic [7:0]  TEMP_LO         = 8'd40
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       ADC_DOUT,
  output logic       ADC_CS_N,
  output logic       ADC_SCLK,
  output logic [7:0] SAMPLE,
  output logic [7:0] TEMP,
  output logic       TEMP_VALID,
  output logic       OVERTEMP,
  output logic       BUSY
);

  localparam int unsigned DIVW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IVW   = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
  localparam int unsigned ACCW  = 8 + AVG_LOG2;
  localparam int unsigned CNTW  = AVG_LOG2 + 1;
  localparam int unsigned NSAMP = 1 << AVG_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SHIFT,
    S_DESELECT,
    S_ACCUM
  } state_t;

  state_t          state, state_nx;
  logic [DIVW-1:0] div, div_nx;
  logic [4:0]      ph, ph_nx;
  logic [IVW-1:0]  interval;
  logic [7:0]      shreg;
  logic [ACCW-1:0] accum;
  logic [CNTW-1:0] count;
  logic            publish;
  logic            aborted;
  logic            div_last;
  logic            start;
  logic            capture;
  logic            cs_n_nx;
  logic            sclk_nx;
  logic            busy_nx;
  logic [7:0]      temp_nx;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nx;
  end

  // ph counts SCLK half-periods (18 per frame); even ph = SCLK high.
  always_comb begin
    div_last = (div == DIVW'(CLK_DIV - 1));
    start    = ENABLE && (interval == '0);
    state_nx = state;
    case (state)
      S_IDLE:     if (start) state_nx = S_SELECT;
      S_SELECT:   if (div_last) state_nx = S_SHIFT;
      S_SHIFT:    if (div_last && ph == 5'd17) state_nx = S_DESELECT;
      S_DESELECT: if (div_last) state_nx = S_ACCUM;
      S_ACCUM:    state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
    div_nx  = (state == S_IDLE || state_nx != state || div_last) ? '0 : div + 1'b1;
    ph_nx   = (state != S_SHIFT) ? '0 : (div_last ? ph + 5'd1 : ph);
    capture = (state == S_SHIFT) && div_last && !ph[0];
    cs_n_nx = !(state_nx == S_SELECT || state_nx == S_SHIFT);
    busy_nx = (state_nx == S_SELECT || state_nx == S_SHIFT || state_nx == S_DESELECT);
    sclk_nx = (state_nx == S_SHIFT) && !ph_nx[0];
    temp_nx = 8'(accum >> AVG_LOG2);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div        <= '0;
      ph         <= '0;
      interval   <= '0;
      shreg      <= '0;
      accum      <= '0;
      count      <= '0;
      publish    <= 1'b0;
      aborted    <= 1'b0;
      ADC_CS_N   <= 1'b1;
      ADC_SCLK   <= 1'b0;
      BUSY       <= 1'b0;
      SAMPLE     <= '0;
      TEMP       <= '0;
      TEMP_VALID <= 1'b0;
      OVERTEMP   <= 1'b0;
    end else begin
      div      <= div_nx;
      ph       <= ph_nx;
      ADC_CS_N <= cs_n_nx;
      ADC_SCLK <= sclk_nx;
      BUSY     <= busy_nx;

      if (state == S_IDLE && start)  interval <= IVW'(SAMPLE_INTERVAL - 1);
      else if (!ENABLE)              interval <= '0;
      else if (interval != '0)       interval <= interval - 1'b1;

      // The null bit shifts in first and falls off the top after 8 more bits.
      if (capture) shreg <= {shreg[6:0], ADC_DOUT};
      if (state == S_SHIFT && state_nx == S_DESELECT) SAMPLE <= shreg;

      if (state == S_IDLE && start) aborted <= 1'b0;
      else if (state != S_IDLE && !ENABLE) aborted <= 1'b1;

      TEMP_VALID <= 1'b0;
      publish    <= 1'b0;
      // Publishing lags the accumulate by one cycle so TEMP reads the final sum.
      if (state == S_ACCUM) begin
        if (aborted || !ENABLE) begin
          accum <= '0;
          count <= '0;
        end else begin
          accum   <= accum + ACCW'(SAMPLE);
          count   <= count + 1'b1;
          publish <= (count == CNTW'(NSAMP - 1));
        end
      end else if (publish) begin
        TEMP       <= temp_nx;
        TEMP_VALID <= 1'b1;
        accum      <= '0;
        count      <= '0;
        if (temp_nx >= TEMP_HI)      OVERTEMP <= 1'b1;
        else if (temp_nx <= TEMP_LO) OVERTEMP <= 1'b0;
      end else if (state == S_IDLE && !ENABLE) begin
        accum <= '0;
        count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lm35_temp_reader.sv
// Directed bench for lm35_temp_reader: two instances (single-sample and
// 4-sample averaging) driven by a serial ADC model fed from code tables.
module tb_lm35_temp_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en   [2];
  logic       dout [2];
  logic       cs_n [2];
  logic       sclk [2];
  logic [7:0] sample [2];
  logic [7:0] temp [2];
  logic       tv   [2];
  logic       ot   [2];
  logic       busy [2];

  always #5 clk = ~clk;

  lm35_temp_reader #(.CLK_DIV(2), .SAMPLE_INTERVAL(200), .AVG_LOG2(0)) dut0 (
    .CLK(clk), .RESET(rst), .ENABLE(en[0]), .ADC_DOUT(dout[0]),
    .ADC_CS_N(cs_n[0]), .ADC_SCLK(sclk[0]), .SAMPLE(sample[0]), .TEMP(temp[0]),
    .TEMP_VALID(tv[0]), .OVERTEMP(ot[0]), .BUSY(busy[0]));

  lm35_temp_reader #(.CLK_DIV(2), .SAMPLE_INTERVAL(10), .AVG_LOG2(2)) dut1 (
    .CLK(clk), .RESET(rst), .ENABLE(en[1]), .ADC_DOUT(dout[1]),
    .ADC_CS_N(cs_n[1]), .ADC_SCLK(sclk[1]), .SAMPLE(sample[1]), .TEMP(temp[1]),
    .TEMP_VALID(tv[1]), .OVERTEMP(ot[1]), .BUSY(busy[1]));

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  logic [7:0] codes [2][16];
  logic [7:0] code_cur [2];
  int frames [2], tv_count [2], tv_cyc [2];
  int cs_len [2], last_cs_len [2], pulses [2], last_pulses [2];
  int hi_run [2], lo_run [2], shape_bad [2], last_shape_bad [2], bitidx [2];
  int start_cyc [2][16];
  int sclk_toggles = 0, tv_wide = 0, ot_stray = 0;
  logic prev_cs [2], prev_sclk [2], prev_tv [2], prev_ot [2];

  typedef struct {
    logic [7:0] code;
    logic [7:0] exp_temp;
    logic       exp_ot;
  } vec_t;
  vec_t vecs [10];

  always @(posedge clk) cyc++;

  // Frame-shape monitor and ADC model: presents the null bit (driven 1) after
  // the first SCLK rise and code bits MSB first after the following rises.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sclk[i] !== prev_sclk[i]) sclk_toggles++;
      if (tv[i]) begin
        if (prev_tv[i]) tv_wide++;
        else begin
          tv_count[i]++;
          tv_cyc[i] = cyc;
        end
      end
      if (ot[i] !== prev_ot[i] && !tv[i] && !rst) ot_stray++;
      if (!cs_n[i]) begin
        if (prev_cs[i]) begin
          if (frames[i] < 16) begin
            code_cur[i] = codes[i][frames[i]];
            start_cyc[i][frames[i]] = cyc;
          end
          frames[i]++;
          cs_len[i] = 0; pulses[i] = 0; hi_run[i] = 0; lo_run[i] = 0;
          shape_bad[i] = 0; bitidx[i] = 0;
        end
        cs_len[i]++;
        if (sclk[i]) begin
          if (!prev_sclk[i]) begin
            if (lo_run[i] != 2) shape_bad[i]++;
            lo_run[i] = 0;
            hi_run[i] = 0;
            pulses[i]++;
            bitidx[i]++;
            if (bitidx[i] == 1) dout[i] = 1'b1;
            else if (bitidx[i] <= 9) dout[i] = code_cur[i][9 - bitidx[i]];
          end
          hi_run[i]++;
        end else begin
          if (prev_sclk[i] && hi_run[i] != 2) shape_bad[i]++;
          lo_run[i]++;
        end
      end else if (!prev_cs[i]) begin
        if (lo_run[i] != 2) shape_bad[i]++;
        last_cs_len[i]    = cs_len[i];
        last_pulses[i]    = pulses[i];
        last_shape_bad[i] = shape_bad[i];
      end
      prev_cs[i]   = cs_n[i];
      prev_sclk[i] = sclk[i];
      prev_tv[i]   = tv[i];
      prev_ot[i]   = ot[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_frames(input int i, input int n, input int budget, input string tag);
    int k = 0;
    while (frames[i] < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(frames[i] >= n), 1);
  endtask

  task automatic wait_tv(input int i, input int n, input int budget, input string tag);
    int k = 0;
    while (tv_count[i] < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(tv_count[i] >= n), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d expected < 100000", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int idle_bad;
    int k;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; dout[i] = 1'b0; frames[i] = 0; tv_count[i] = 0; tv_cyc[i] = 0;
      prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0; prev_tv[i] = 1'b0; prev_ot[i] = 1'b0;
      cs_len[i] = 0; last_cs_len[i] = 0; pulses[i] = 0; last_pulses[i] = 0;
      hi_run[i] = 0; lo_run[i] = 0; shape_bad[i] = 0; last_shape_bad[i] = 0; bitidx[i] = 0;
      code_cur[i] = '0;
      for (int j = 0; j < 16; j++) begin
        codes[i][j] = 8'h00;
        start_cyc[i][j] = 0;
      end
    end
    vecs[0] = '{8'h2A, 8'h2A, 1'b0};
    vecs[1] = '{8'd44, 8'd44, 1'b0};
    vecs[2] = '{8'd45, 8'd45, 1'b1};
    vecs[3] = '{8'd42, 8'd42, 1'b1};
    vecs[4] = '{8'd40, 8'd40, 1'b0};
    vecs[5] = '{8'd41, 8'd41, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1};
    vecs[7] = '{8'h00, 8'h00, 1'b0};
    vecs[8] = '{8'd46, 8'd46, 1'b1};
    vecs[9] = '{8'd41, 8'd41, 1'b1};
    for (int v = 0; v < 10; v++) codes[0][v] = vecs[v].code;
    codes[0][10] = 8'h55;
    codes[1][0] = 8'd20;  codes[1][1] = 8'd21; codes[1][2] = 8'd21; codes[1][3] = 8'd21;
    codes[1][4] = 8'd100; codes[1][5] = 8'd100;
    codes[1][6] = 8'd30;  codes[1][7] = 8'd31; codes[1][8] = 8'd32; codes[1][9] = 8'd33;

    // Reset and idle with ENABLE low.
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_cs_n", 32'(cs_n[0]), 1);
    check("rst_sclk", 32'(sclk[0]), 0);
    check("rst_outputs", {sample[0], temp[0], 5'(0), tv[0], ot[0], busy[0]}, 0);
    idle_bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      for (int i = 0; i < 2; i++)
        if (cs_n[i] !== 1'b1 || sclk[i] !== 1'b0 || sample[i] !== 8'h00 || temp[i] !== 8'h00 ||
            tv[i] !== 1'b0 || ot[i] !== 1'b0 || busy[i] !== 1'b0) idle_bad++;
    end
    check("idle_outputs_bad_cycles", idle_bad, 0);
    check("idle_sclk_toggles", sclk_toggles, 0);
    check("idle_frames", frames[0] + frames[1], 0);

    // Single-sample instance: frame shape, latency, pass-through and hysteresis.
    en[0] = 1'b1;
    for (int v = 0; v < 10; v++) begin
      wait_frames(0, v + 1, 400, $sformatf("v%0d_frame_start", v));
      wait_tv(0, v + 1, 100, $sformatf("v%0d_temp_valid", v));
      check($sformatf("v%0d_sample", v), sample[0], vecs[v].code);
      check($sformatf("v%0d_temp", v), temp[0], vecs[v].exp_temp);
      check($sformatf("v%0d_overtemp", v), 32'(ot[0]), 32'(vecs[v].exp_ot));
      check($sformatf("v%0d_latency", v), tv_cyc[0] - start_cyc[0][v], 42);
      if (v == 0) begin
        check("frame_cs_low_cycles", last_cs_len[0], 38);
        check("frame_sclk_pulses", last_pulses[0], 9);
        check("frame_sclk_shape_errors", last_shape_bad[0], 0);
      end
      if (v == 1) check("interval_200_spacing", start_cyc[0][1] - start_cyc[0][0], 200);
    end
    en[0] = 1'b0;

    // Averaging instance: truncation, back-to-back frames, ENABLE drop.
    en[1] = 1'b1;
    wait_frames(1, 2, 100, "b2b_second_start");
    check("b2b_spacing", start_cyc[1][1] - start_cyc[1][0], 42);
    wait_tv(1, 1, 250, "avg1_temp_valid");
    check("avg1_valid_after_4th", tv_cyc[1] - start_cyc[1][3], 42);
    check("avg1_temp", temp[1], 20);
    check("avg1_overtemp", 32'(ot[1]), 0);
    wait_frames(1, 6, 200, "drop_frame_start");
    check("b2b_spacing_later", start_cyc[1][5] - start_cyc[1][4], 42);
    repeat (10) tick();
    en[1] = 1'b0;
    repeat (60) tick();
    check("drop_no_temp_valid", tv_count[1], 1);
    check("drop_no_new_frame", frames[1], 6);
    check("drop_sample_updated", sample[1], 100);
    check("drop_temp_held", temp[1], 20);
    check("drop_idle_cs_busy", {31'(0), cs_n[1]} | {busy[1], 31'(0)}, 1);
    en[1] = 1'b1;
    tick();
    check("restart_immediate_cs_n", 32'(cs_n[1]), 0);
    wait_tv(1, 2, 250, "avg2_temp_valid");
    check("avg2_temp_fresh", temp[1], 31);
    check("avg2_valid_after_4th", tv_cyc[1] - start_cyc[1][9], 42);
    en[1] = 1'b0;

    check("temp_valid_single_cycle", tv_wide, 0);
    check("overtemp_changes_only_with_valid", ot_stray, 0);

    // Reset asserted while SCLK is high in the middle of a frame.
    en[0] = 1'b1;
    k = 0;
    while (sclk[0] !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("midshift_reached", 32'(sclk[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_cs_n", 32'(cs_n[0]), 1);
    check("midrst_sclk", 32'(sclk[0]), 0);
    check("midrst_sample_temp", {16'(0), sample[0], temp[0]}, 0);
    check("midrst_flags", {29'(0), tv[0], ot[0], busy[0]}, 0);
    check("midrst_temp_avg_inst", temp[1], 0);
    en[0] = 1'b0;
    #20;
    rst = 1'b0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
